// File: rtl/op_lut_pkg.sv
// -----------------------------------------------------------------------------
// op_lut_pkg
// Shared constants for the output-port-lookup header snooping logic:
//   - byte offsets of the Ethernet/IPv4 header fields inside a 256-bit AXIS word
//     (byte 0 sits at [255:248])
//   - IPv4 header constants (plain 20-byte header ver/IHL, TTL decrement adjust)
//   - FSM encoding and the packed result record stored in the result FIFO
// -----------------------------------------------------------------------------
package op_lut_pkg;

   localparam int C_AXIS_W = 256;

   // MSB position of byte b within a bus word
   function automatic int byte_msb(input int b);
      return C_AXIS_W - 1 - 8 * b;
   endfunction

   localparam int C_IP_HDR_BYTE  = 14;   // ver/IHL, first IPv4 byte
   localparam int C_TTL_BYTE     = 22;
   localparam int C_CSUM_BYTE    = 24;
   localparam int C_W1_HW_BYTE   = 0;    // last IPv4 halfword spills into word 1

   localparam int C_VER_IHL_MSB  = byte_msb(C_IP_HDR_BYTE);
   localparam int C_TTL_MSB      = byte_msb(C_TTL_BYTE);
   localparam int C_CSUM_MSB     = byte_msb(C_CSUM_BYTE);
   localparam int C_W1_HW_MSB    = byte_msb(C_W1_HW_BYTE);

   // bytes 14..31 of word 0 are nine header halfwords
   localparam int C_W0_HALFWORDS = 9;

   localparam logic [7:0]  C_VER_IHL_NO_OPT = 8'h45;
   localparam logic [15:0] C_TTL_DEC_ADJ    = 16'h0100;
   localparam logic [15:0] C_CSUM_OK        = 16'hFFFF;

   localparam int C_RESULT_W = 27;

   typedef enum logic [1:0] {
      ST_WORD0    = 2'd0,
      ST_WORD1    = 2'd1,
      ST_WAIT_EOP = 2'd2
   } ip_state_e;

   typedef struct packed {
      logic        is_good;
      logic        has_options;
      logic        ttl_good;
      logic [7:0]  new_ttl;
      logic [15:0] new_csum;
   } ip_result_t;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// -----------------------------------------------------------------------------
// fallthrough_small_fifo
// Small first-word-fallthrough FIFO: the head entry is visible on dout
// whenever empty is low; rd_en pops it.
//   clk, reset   : clock, synchronous active-high reset (empties the FIFO)
//   din, wr_en   : push port; a push while full (and not popping) is dropped
//   rd_en        : pop the head; ignored while empty
//   dout         : head entry
//   full         : count == depth
//   nearly_full  : count >= depth-1
//   empty        : count == 0
// -----------------------------------------------------------------------------
module fallthrough_small_fifo #(
   parameter int WIDTH          = 27,
   parameter int MAX_DEPTH_BITS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             nearly_full,
   output logic             empty
);

   localparam int DEPTH = 1 << MAX_DEPTH_BITS;
   localparam logic [MAX_DEPTH_BITS:0] C_FULL   = {1'b1, {MAX_DEPTH_BITS{1'b0}}};
   localparam logic [MAX_DEPTH_BITS:0] C_NEARLY = {1'b0, {MAX_DEPTH_BITS{1'b1}}};

   logic [WIDTH-1:0]          r_mem [DEPTH];
   logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
   logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
   logic [MAX_DEPTH_BITS:0]   r_count;
   logic                      w_do_rd;
   logic                      w_do_wr;

   assign w_do_rd = rd_en && (r_count != '0);
   // a pop in the same cycle frees the slot the push needs
   assign w_do_wr = wr_en && ((r_count != C_FULL) || w_do_rd);

   assign dout        = r_mem[r_rd_ptr];
   assign empty       = (r_count == '0);
   assign full        = (r_count == C_FULL);
   assign nearly_full = (r_count >= C_NEARLY);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_wr) r_mem[r_wr_ptr] <= din;
   end

endmodule

// File: rtl/ip_checksum_ttl.sv
// -----------------------------------------------------------------------------
// ip_checksum_ttl
// Snoops an AXIS packet stream (Ethernet + IPv4), verifies the IPv4 header
// checksum, checks/decrements TTL and queues one result record per packet.
//   clk, reset          : clock, synchronous active-high reset
//   in_tdata            : snooped word, byte 0 at [255:248]
//   in_tlast            : last word of packet
//   in_word_vld         : word accepted upstream this cycle
//   in_rdy              : result FIFO can take another packet
//   rd_checksum         : pop head result
//   ip_checksum_vld     : result available
//   ip_checksum_is_good : header checksum verifies (0 for single-word packets)
//   ip_hdr_has_options  : ver/IHL != 0x45 (1 for single-word packets)
//   ip_ttl_is_good      : TTL > 1
//   ip_new_ttl          : TTL-1 mod 256
//   ip_new_checksum     : checksum after TTL decrement
// Build option IP_CHECKSUM_VERIFY_EN: when defined, the one's-complement sum
// is built and checked; otherwise is_good is 1 for every multi-word packet.
// -----------------------------------------------------------------------------
module ip_checksum_ttl
   import op_lut_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int INFO_FIFO_DEPTH_BITS = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0] in_tdata,
   input  logic                           in_tlast,
   input  logic                           in_word_vld,
   output logic                           in_rdy,
   input  logic                           rd_checksum,
   output logic                           ip_checksum_vld,
   output logic                           ip_checksum_is_good,
   output logic                           ip_hdr_has_options,
   output logic                           ip_ttl_is_good,
   output logic [7:0]                     ip_new_ttl,
   output logic [15:0]                    ip_new_checksum
);

   function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] t;
      t = {1'b0, a} + {1'b0, b};
      return t[15:0] + {15'd0, t[16]};
   endfunction

   ip_state_e   r_state;
   ip_state_e   w_state_nxt;
   logic        w_take_w0;
   logic        w_take_w1;

   logic [7:0]  r_w0_ttl;
   logic [15:0] r_w0_csum;
   logic [7:0]  r_w0_verihl;

   logic        r_vld_p0;
   logic        r_single_p0;
   logic [7:0]  r_ttl_p0;
   logic [15:0] r_csum_p0;
   logic [7:0]  r_verihl_p0;
   ip_result_t  w_res_p0;

   logic        r_vld_p1;
   ip_result_t  r_res_p1;

   logic [C_RESULT_W-1:0] w_fifo_dout;
   ip_result_t  w_head;
   ip_result_t  w_out;
   logic        w_fifo_full;
   logic        w_fifo_nearly_full;
   logic        w_fifo_empty;
   logic        w_unused_bits;

`ifdef IP_CHECKSUM_VERIFY_EN
   // 20-bit accumulation with end-around carries folded twice
   function automatic logic [15:0] fold_carries(input logic [19:0] s);
      logic [16:0] t1;
      t1 = {1'b0, s[15:0]} + {13'd0, s[19:16]};
      return t1[15:0] + {15'd0, t1[16]};
   endfunction

   logic [19:0] w_sum9;
   logic [19:0] r_w0_sum;
   logic [19:0] r_sum_p0;

   always_comb begin
      w_sum9 = '0;
      for (int i = 0; i < C_W0_HALFWORDS; i++)
         w_sum9 = w_sum9 + {4'd0, in_tdata[C_VER_IHL_MSB - 16*i -: 16]};
   end
`endif

   assign w_take_w0 = in_word_vld && (r_state == ST_WORD0);
   assign w_take_w1 = in_word_vld && (r_state == ST_WORD1);

   always_comb begin
      w_state_nxt = r_state;
      if (in_word_vld) begin
         case (r_state)
            ST_WORD0:    w_state_nxt = in_tlast ? ST_WORD0 : ST_WORD1;
            ST_WORD1:    w_state_nxt = in_tlast ? ST_WORD0 : ST_WAIT_EOP;
            ST_WAIT_EOP: w_state_nxt = in_tlast ? ST_WORD0 : ST_WAIT_EOP;
            default:     w_state_nxt = ST_WORD0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_WORD0;
         r_vld_p0 <= 1'b0;
         r_vld_p1 <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_vld_p0 <= (w_take_w0 && in_tlast) || w_take_w1;
         r_vld_p1 <= r_vld_p0;
      end
   end

   // ---- stage p0: header fields captured, sum of all ten halfwords ----
   always_ff @(posedge clk) begin
      if (w_take_w0) begin
         r_w0_ttl    <= in_tdata[C_TTL_MSB -: 8];
         r_w0_csum   <= in_tdata[C_CSUM_MSB -: 16];
         r_w0_verihl <= in_tdata[C_VER_IHL_MSB -: 8];
`ifdef IP_CHECKSUM_VERIFY_EN
         r_w0_sum    <= w_sum9;
`endif
      end
      // a single-word packet takes its fields straight from word 0
      if (w_take_w0 || w_take_w1) begin
         r_single_p0 <= w_take_w0;
         r_ttl_p0    <= w_take_w0 ? in_tdata[C_TTL_MSB -: 8]      : r_w0_ttl;
         r_csum_p0   <= w_take_w0 ? in_tdata[C_CSUM_MSB -: 16]    : r_w0_csum;
         r_verihl_p0 <= w_take_w0 ? in_tdata[C_VER_IHL_MSB -: 8]  : r_w0_verihl;
`ifdef IP_CHECKSUM_VERIFY_EN
         r_sum_p0    <= r_w0_sum + {4'd0, in_tdata[C_W1_HW_MSB -: 16]};
`endif
      end
   end

   always_comb begin
      w_res_p0             = '0;
      w_res_p0.ttl_good    = (r_ttl_p0 > 8'd1);
      w_res_p0.new_ttl     = r_ttl_p0 - 8'd1;
      // TTL sits in the high byte of its halfword, so the stored complement rises by 0x0100
      w_res_p0.new_csum    = ones_add16(r_csum_p0, C_TTL_DEC_ADJ);
      w_res_p0.has_options = r_single_p0 || (r_verihl_p0 != C_VER_IHL_NO_OPT);
`ifdef IP_CHECKSUM_VERIFY_EN
      w_res_p0.is_good     = !r_single_p0 && (fold_carries(r_sum_p0) == C_CSUM_OK);
`else
      w_res_p0.is_good     = !r_single_p0;
`endif
   end

   // ---- stage p1: finished result record, pushed into the FIFO ----
   always_ff @(posedge clk) begin
      r_res_p1 <= w_res_p0;
   end

   fallthrough_small_fifo #(
      .WIDTH          (C_RESULT_W),
      .MAX_DEPTH_BITS (INFO_FIFO_DEPTH_BITS)
   ) u_result_fifo (
      .clk         (clk),
      .reset       (reset),
      .din         (r_res_p1),
      .wr_en       (r_vld_p1),
      .rd_en       (rd_checksum),
      .dout        (w_fifo_dout),
      .full        (w_fifo_full),
      .nearly_full (w_fifo_nearly_full),
      .empty       (w_fifo_empty)
   );

   // nearly_full leaves room for the packet already in the pipeline
   assign in_rdy          = !w_fifo_nearly_full;
   assign ip_checksum_vld = !w_fifo_empty;

   // outputs read zero while nothing is queued (including right after reset)
   assign w_head = w_fifo_dout;
   assign w_out  = w_fifo_empty ? '0 : w_head;

   assign ip_checksum_is_good = w_out.is_good;
   assign ip_hdr_has_options  = w_out.has_options;
   assign ip_ttl_is_good      = w_out.ttl_good;
   assign ip_new_ttl          = w_out.new_ttl;
   assign ip_new_checksum     = w_out.new_csum;

   assign w_unused_bits = ^in_tdata ^ w_fifo_full;

endmodule
